dense_argmax_seq: RTL and testbench
===================================

Name: dense_argmax_seq

Overview:
- Parametrised, time-multiplexed successor to the fully-parallel final dense layer plus argmax stage.
- Accepts the previous stage's feature vector as a valid/ready stream, one element per cycle.
- Multiply-accumulates against NCLASSES weight columns read from a combinational weight ROM, then subtracts per-class bias.
- Applies ReLU with scaling and saturation, scans for the argmax, and reports the winning class and score, a result-valid pulse, and a class-changed pulse.

Parameters:
- NINPUTS, 144, feature elements per frame (≥2).
- NCLASSES, 4, output classes (≥2).
- DWIDTH, 35, signed width of feature and weight elements.
- ACCWIDTH, 80, signed accumulator width; must be ≥ 2*DWIDTH + clog2(NINPUTS) + 1.
- OUTWIDTH, 17, signed width of post-ReLU scores.
- SHIFT, 54, arithmetic right shift applied after bias subtraction.
- IDXW, clog2(NCLASSES), class index width (derived).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  feature element valid.
- in_ready  out  1  block accepts an element.
- in_data  in  DWIDTH  signed feature element.
- in_last  in  1  marks the final element of a frame.
- w_addr  out  clog2(NINPUTS)  weight ROM address, equal to the current element count.
- w_data  in  NCLASSES*DWIDTH  signed weights for w_addr; class c occupies bits [c*DWIDTH +: DWIDTH]; combinational, same cycle.
- bias  in  NCLASSES*ACCWIDTH  signed per-class bias, packed like w_data; sampled in SCORE.
- out_valid  out  1  one-cycle result strobe.
- max_index  out  IDXW  winning class.
- max_value  out  OUTWIDTH  winning score.
- changed_pulse  out  1  with out_valid: max_index differs from the previous frame's.
- len_err  out  1  with out_valid: in_last was not asserted exactly on element NINPUTS-1.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State returns to ACCUM; count=0; all accumulators=0.
  - out_valid, changed_pulse, len_err, max_index, max_value=0; the previous-index register=0.
  - Reset mid-frame discards the partial frame; no out_valid is produced for it.
- State ACCUM:
  - in_ready=1.
  - Beat = in_valid & in_ready. On each beat: acc[c] += sext(w_data[c]) * sext(in_data) for every c; count++.
  - Record the flag lastok = in_last on the beat where count==NINPUTS-1.
  - The frame always ends on the NINPUTS-th beat regardless of in_last. An early in_last is ignored but forces len_err.
  - No beat means no state change, including when in_valid is held low indefinitely.
- State SCORE (1 cycle):
  - in_ready=0.
  - For each class: s = acc[c] - bias[c] at ACCWIDTH.
  - If s<0, score[c]=0. Otherwise t = s >>> SHIFT, and score[c] = min(t, 2^(OUTWIDTH-1)-1).
- State SCAN (NCLASSES-1 cycles):
  - Sequential compare over classes 1..NCLASSES-1 against the running best, which starts at class 0.
  - Replace only on strictly greater, so ties resolve to the lowest index.
- State DONE (1 cycle):
  - out_valid=1; max_index and max_value update.
  - changed_pulse = (new index != previous index); the previous index register updates.
  - len_err = !lastok or an early in_last was seen.
  - Accumulators and count clear; next state ACCUM.
- Output holding: max_index and max_value hold between frames. out_valid, changed_pulse and len_err are 0 outside DONE.
- Latency: the last beat at cycle T gives out_valid at T+1+NCLASSES.
- Frame pacing: minimum frame period is NINPUTS+NCLASSES+1 cycles. in_ready is low for NCLASSES+1 cycles between frames.
- Arithmetic: all products and sums are signed at ACCWIDTH. Accumulator overflow cannot occur when the ACCWIDTH rule above is met.

Test Plan:
1. Bench config NINPUTS=4, NCLASSES=4, SHIFT=0, bias=0, w[c][i]=(i==c)?1:0, frame {5,9,2,7} with in_last on the 4th beat:
   - out_valid exactly 5 cycles after the last beat.
   - max_index=1, max_value=9, changed_pulse=1, len_err=0.
2. Same config, frame {4,4,4,4}, then the identical frame again:
   - Tie resolves to max_index=0, max_value=4, changed_pulse=1 (previous was 1).
   - Repeat frame gives changed_pulse=0.
3. Bias {100,0,0,0}, frame {50,-3,-8,-1}:
   - Class 0 is negative and clamps to 0; all scores are 0.
   - max_index=0, max_value=0.
4. Saturation, OUTWIDTH=8: frame driving class 2 to 1000 → max_value=127, max_index=2.
5. in_valid toggled every other cycle; in_last on the 2nd beat and not on the 4th:
   - Result is identical to scenario 1's frame values, with len_err=1.
6. reset_n pulsed low after 2 beats, then a full frame sent:
   - No out_valid for the aborted frame.
   - The new frame's result matches scenario 1 with changed_pulse=1 (previous index reset to 0).

Source files
------------

// File: rtl/dense_argmax_seq.sv
// Time-multiplexed final dense layer with bias, scaled ReLU and argmax.
// Features arrive one element per beat. Every class accumulates in parallel
// against a combinational weight ROM. The winner is then found with a
// sequential scan over the class scores.
module dense_argmax_seq #(
   parameter int unsigned NINPUTS  = 144,
   parameter int unsigned NCLASSES = 4,
   parameter int unsigned DWIDTH   = 35,
   parameter int unsigned ACCWIDTH = 80,
   parameter int unsigned OUTWIDTH = 17,
   parameter int unsigned SHIFT    = 54,
   parameter int unsigned IDXW     = $clog2(NCLASSES)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DWIDTH-1:0]            in_data,
   input  logic                         in_last,
   output logic [$clog2(NINPUTS)-1:0]   w_addr,
   input  logic [NCLASSES*DWIDTH-1:0]   w_data,
   input  logic [NCLASSES*ACCWIDTH-1:0] bias,
   output logic                         out_valid,
   output logic [IDXW-1:0]              max_index,
   output logic [OUTWIDTH-1:0]          max_value,
   output logic                         changed_pulse,
   output logic                         len_err
);

   localparam int unsigned CW = $clog2(NINPUTS);
   localparam logic [CW-1:0] LastCount = CW'(NINPUTS - 1);
   localparam logic [IDXW-1:0] LastIdx = IDXW'(NCLASSES - 1);
   localparam logic signed [ACCWIDTH-1:0] SatAcc =
      {{(ACCWIDTH - OUTWIDTH + 1){1'b0}}, {(OUTWIDTH - 1){1'b1}}};
   localparam logic signed [OUTWIDTH-1:0] SatOut = {1'b0, {(OUTWIDTH - 1){1'b1}}};

   typedef enum logic [1:0] {StAccum, StScore, StScan, StDone} state_e;

   state_e                      state_q, state_d;
   logic [CW-1:0]               count_q, count_d;
   logic signed [ACCWIDTH-1:0]  acc_q [NCLASSES];
   logic signed [ACCWIDTH-1:0]  acc_d [NCLASSES];
   logic signed [OUTWIDTH-1:0]  score_q [NCLASSES];
   logic signed [OUTWIDTH-1:0]  score_d [NCLASSES];
   logic signed [OUTWIDTH-1:0]  score_c [NCLASSES];
   logic signed [ACCWIDTH-1:0]  prod [NCLASSES];
   logic [IDXW-1:0]             scan_q, scan_d;
   logic [IDXW-1:0]             best_idx_q, best_idx_d;
   logic signed [OUTWIDTH-1:0]  best_val_q, best_val_d;
   logic                        lastok_q, lastok_d;
   logic                        early_q, early_d;
   logic [IDXW-1:0]             prev_q, prev_d;
   logic [IDXW-1:0]             max_index_q, max_index_d;
   logic [OUTWIDTH-1:0]         max_value_q, max_value_d;
   logic                        beat;
   logic                        final_beat;

   assign in_ready      = (state_q == StAccum);
   assign beat          = in_valid & in_ready;
   assign final_beat    = (count_q == LastCount);
   assign w_addr        = count_q;
   assign max_index     = max_index_q;
   assign max_value     = max_value_q;
   // The strobes are decoded from the DONE state, so reset clears them with the FSM.
   assign out_valid     = (state_q == StDone);
   assign changed_pulse = (state_q == StDone) && (max_index_q != prev_q);
   assign len_err       = (state_q == StDone) && (!lastok_q || early_q);

   // Per-class product of the current feature with its weight, signed at ACCWIDTH.
   always_comb begin
      for (int c = 0; c < NCLASSES; c++) begin
         prod[c] = ACCWIDTH'($signed(w_data[c*DWIDTH +: DWIDTH])) *
                   ACCWIDTH'($signed(in_data));
      end
   end

   // Bias subtraction, ReLU, arithmetic shift and saturation per class.
   always_comb begin
      logic signed [ACCWIDTH-1:0] diff;
      logic signed [ACCWIDTH-1:0] shifted;
      diff    = '0;
      shifted = '0;
      for (int c = 0; c < NCLASSES; c++) begin
         diff    = acc_q[c] - $signed(bias[c*ACCWIDTH +: ACCWIDTH]);
         shifted = diff >>> SHIFT;
         if (diff < 0) begin
            score_c[c] = '0;
         end else if (shifted > SatAcc) begin
            score_c[c] = SatOut;
         end else begin
            score_c[c] = shifted[OUTWIDTH-1:0];
         end
      end
   end

   // Next-state logic: accumulate, score, scan, then publish the result.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      acc_d       = acc_q;
      score_d     = score_q;
      scan_d      = scan_q;
      best_idx_d  = best_idx_q;
      best_val_d  = best_val_q;
      lastok_d    = lastok_q;
      early_d     = early_q;
      prev_d      = prev_q;
      max_index_d = max_index_q;
      max_value_d = max_value_q;
      unique case (state_q)
         StAccum: begin
            if (beat) begin
               for (int c = 0; c < NCLASSES; c++) begin
                  acc_d[c] = acc_q[c] + prod[c];
               end
               // The frame ends on the NINPUTS-th beat whatever in_last says.
               if (final_beat) begin
                  lastok_d = in_last;
                  state_d  = StScore;
               end else begin
                  count_d = count_q + 1'b1;
                  if (in_last) early_d = 1'b1;
               end
            end
         end
         StScore: begin
            score_d    = score_c;
            best_idx_d = '0;
            best_val_d = score_c[0];
            scan_d     = IDXW'(1);
            state_d    = StScan;
         end
         StScan: begin
            // Strictly greater keeps the lowest index on ties.
            if (score_q[scan_q] > best_val_q) begin
               best_idx_d = scan_q;
               best_val_d = score_q[scan_q];
            end
            if (scan_q == LastIdx) begin
               max_index_d = best_idx_d;
               max_value_d = best_val_d;
               state_d     = StDone;
            end else begin
               scan_d = scan_q + 1'b1;
            end
         end
         StDone: begin
            prev_d   = max_index_q;
            count_d  = '0;
            lastok_d = 1'b0;
            early_d  = 1'b0;
            for (int c = 0; c < NCLASSES; c++) begin
               acc_d[c] = '0;
            end
            state_d = StAccum;
         end
         default: state_d = StAccum;
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StAccum;
         count_q     <= '0;
         scan_q      <= '0;
         best_idx_q  <= '0;
         best_val_q  <= '0;
         lastok_q    <= 1'b0;
         early_q     <= 1'b0;
         prev_q      <= '0;
         max_index_q <= '0;
         max_value_q <= '0;
         for (int c = 0; c < NCLASSES; c++) begin
            acc_q[c]   <= '0;
            score_q[c] <= '0;
         end
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         scan_q      <= scan_d;
         best_idx_q  <= best_idx_d;
         best_val_q  <= best_val_d;
         lastok_q    <= lastok_d;
         early_q     <= early_d;
         prev_q      <= prev_d;
         max_index_q <= max_index_d;
         max_value_q <= max_value_d;
         for (int c = 0; c < NCLASSES; c++) begin
            acc_q[c]   <= acc_d[c];
            score_q[c] <= score_d[c];
         end
      end
   end

endmodule

// File: tb/tb_dense_argmax_seq.sv
// Scoreboard bench for dense_argmax_seq: directed scenarios plus random frames
// checked against a plain-arithmetic dot-product / ReLU / argmax model.
module tb_dense_argmax_seq;

   localparam int NI = 4;
   localparam int NC = 4;
   localparam int DW = 16;
   localparam int AW = 40;
   localparam int OW = 8;
   localparam int SH = 0;
   localparam int IW = 2;
   localparam int CWD = 2;
   localparam int SATV = 127;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     in_data;
   logic              in_last;
   logic [CWD-1:0]    w_addr;
   logic [NC*DW-1:0]  w_data;
   logic [NC*AW-1:0]  bias;
   logic              out_valid;
   logic [IW-1:0]     max_index;
   logic [OW-1:0]     max_value;
   logic              changed_pulse;
   logic              len_err;

   logic signed [DW-1:0] wrom [NI][NC];
   logic signed [AW-1:0] bias_v [NC];

   typedef struct {
      int idx;
      int val;
      int chg;
      int lerr;
      int due;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   model_prev = 0;

   dense_argmax_seq #(
      .NINPUTS (NI),
      .NCLASSES(NC),
      .DWIDTH  (DW),
      .ACCWIDTH(AW),
      .OUTWIDTH(OW),
      .SHIFT   (SH)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .w_addr       (w_addr),
      .w_data       (w_data),
      .bias         (bias),
      .out_valid    (out_valid),
      .max_index    (max_index),
      .max_value    (max_value),
      .changed_pulse(changed_pulse),
      .len_err      (len_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Combinational weight ROM and packed bias.
   always_comb begin
      for (int c = 0; c < NC; c++) begin
         w_data[c*DW +: DW] = wrom[w_addr][c];
         bias[c*AW +: AW]   = bias_v[c];
      end
   end

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever a result is presented.
   always @(negedge clk) begin
      if (reset_n) begin
         if (out_valid) begin
            if (q.size() == 0) begin
               check("unexpected_out_valid", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("max_index", int'(max_index), e.idx);
               check("max_value", int'(max_value), e.val);
               check("changed_pulse", int'(changed_pulse), e.chg);
               check("len_err", int'(len_err), e.lerr);
               check("latency", cyc, e.due);
            end
         end else begin
            check("pulses_idle", int'({changed_pulse, len_err}), 0);
         end
      end
   end

   // Reference model: dot product minus bias, ReLU, shift, clamp, first max.
   task automatic model_push(input int x [NI], input bit lv [NI], input int beat_cyc);
      exp_t    e;
      longint  s;
      int      sc [NC];
      bit      early;
      early = 1'b0;
      for (int c = 0; c < NC; c++) begin
         s = 0;
         for (int i = 0; i < NI; i++) s += longint'(wrom[i][c]) * longint'(x[i]);
         s -= longint'(bias_v[c]);
         if (s < 0) sc[c] = 0;
         else begin
            s = s >>> SH;
            sc[c] = (s > SATV) ? SATV : int'(s);
         end
      end
      e.idx = 0;
      for (int c = 1; c < NC; c++) if (sc[c] > sc[e.idx]) e.idx = c;
      e.val = sc[e.idx];
      e.chg = (e.idx != model_prev) ? 1 : 0;
      model_prev = e.idx;
      for (int i = 0; i < NI - 1; i++) if (lv[i]) early = 1'b1;
      e.lerr = (early || !lv[NI-1]) ? 1 : 0;
      // Last beat captured at edge beat_cyc; DONE is visible NC edges later.
      e.due = beat_cyc + NC;
      q.push_back(e);
   endtask

   task automatic send_frame(input int x [NI], input bit lv [NI], input int gap, input bit rgap);
      int g;
      int waitc;
      bit rdy;
      int beat_cyc;
      beat_cyc = 0;
      for (int i = 0; i < NI; i++) begin
         g = rgap ? int'($urandom_range(0, gap)) : gap;
         if (i == 0) g = 0;
         repeat (g) begin
            @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         in_data  = DW'(x[i]);
         in_last  = lv[i];
         waitc = 0;
         rdy   = 1'b0;
         while (!rdy && waitc < 100) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            waitc++;
         end
         #1;
         if (!rdy) check("in_ready_timeout", 0, 1);
         beat_cyc = cyc;
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
      model_push(x, lv, beat_cyc);
   endtask

   task automatic wait_drain();
      int waitc;
      waitc = 0;
      while (q.size() != 0 && waitc < 200) begin
         @(posedge clk);
         waitc++;
      end
      if (q.size() != 0) check("drain_timeout", q.size(), 0);
      #1;
   endtask

   task automatic set_identity();
      for (int i = 0; i < NI; i++)
         for (int c = 0; c < NC; c++) wrom[i][c] = (i == c) ? DW'(1) : DW'(0);
      for (int c = 0; c < NC; c++) bias_v[c] = '0;
   endtask

   initial begin
      int x [NI];
      bit lv [NI];
      bit lnorm [NI];
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      set_identity();
      lnorm = '{0, 0, 0, 1};
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_max_index", int'(max_index), 0);
      check("rst_max_value", int'(max_value), 0);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_w_addr", int'(w_addr), 0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: basic frame, winner class 1.
      x = '{5, 9, 2, 7};
      send_frame(x, lnorm, 0, 1'b0);
      wait_drain();
      // 2: tie resolves low, then identical frame shows no change.
      x = '{4, 4, 4, 4};
      send_frame(x, lnorm, 0, 1'b0);
      send_frame(x, lnorm, 0, 1'b0);
      wait_drain();
      // 3: bias drives class 0 negative; everything clamps to 0.
      bias_v[0] = AW'(100);
      x = '{50, -3, -8, -1};
      send_frame(x, lnorm, 0, 1'b0);
      wait_drain();
      // 4: saturation at 2^(OW-1)-1.
      bias_v[0] = '0;
      x = '{0, 0, 1000, 0};
      send_frame(x, lnorm, 0, 1'b0);
      wait_drain();
      // 5: valid toggling, early in_last and missing final in_last.
      x  = '{5, 9, 2, 7};
      lv = '{0, 1, 0, 0};
      send_frame(x, lv, 1, 1'b0);
      wait_drain();
      // Long idle gaps mid-frame must not disturb the frame.
      send_frame(x, lnorm, 12, 1'b0);
      wait_drain();
      // 6: reset after two beats discards the partial frame.
      x = '{0, 0, 3, 0};
      send_frame(x, lnorm, 0, 1'b0);
      wait_drain();
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(i + 20);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("w_addr_mid", int'(w_addr), 2);
      #2 reset_n = 1'b0;
      #3 reset_n = 1'b1;
      model_prev = 0;
      repeat (10) @(posedge clk);
      #1;
      check("w_addr_after_rst", int'(w_addr), 0);
      x = '{5, 9, 2, 7};
      send_frame(x, lnorm, 0, 1'b0);
      wait_drain();

      // Random phase: back-to-back frames against random weights and bias.
      for (int grp = 0; grp < 4; grp++) begin
         for (int i = 0; i < NI; i++)
            for (int c = 0; c < NC; c++) wrom[i][c] = DW'(int'($urandom_range(0, 16)) - 8);
         for (int c = 0; c < NC; c++) bias_v[c] = AW'(int'($urandom_range(0, 100)) - 50);
         for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < NI; i++) begin
               x[i]  = int'($urandom_range(0, 40)) - 20;
               lv[i] = (i == NI - 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            end
            send_frame(x, lv, 2, 1'b1);
         end
         wait_drain();
      end

      repeat (5) @(posedge clk);
      #1;
      check("queue_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
